// File: rtl/sync_filter_if.sv
// Handshake-free signal bundle between raw board inputs and the filter.
// Master drives raw inputs and the strobe; slave returns conditioned levels.
interface sync_filter_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] in;
    logic                sample_en;
    logic [CHANNELS-1:0] out;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic                change;

    modport master (
        output in,
        output sample_en,
        input  out,
        input  rise,
        input  fall,
        input  change
    );

    modport slave (
        input  in,
        input  sample_en,
        output out,
        output rise,
        output fall,
        output change
    );
endinterface

// File: rtl/sync_filter.sv
// Per-channel synchroniser chain followed by a consecutive-sample glitch
// filter; emits a stable level plus registered one-cycle rise/fall pulses.
module sync_filter #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3,
    parameter bit RESET_VAL   = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    sync_filter_if.slave  bus
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW:0] LEN = (CW + 1)'(FILTER_LEN);
    localparam logic [CHANNELS-1:0] RST_VEC = {CHANNELS{RESET_VAL}};

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] sync_d [SYNC_STAGES];
    logic [CW-1:0]       cnt_q  [CHANNELS];
    logic [CW-1:0]       cnt_d  [CHANNELS];
    logic [CW:0]         cnt_inc [CHANNELS];
    logic [CHANNELS-1:0] out_q;
    logic [CHANNELS-1:0] out_d;
    logic [CHANNELS-1:0] rise_q;
    logic [CHANNELS-1:0] rise_d;
    logic [CHANNELS-1:0] fall_q;
    logic [CHANNELS-1:0] fall_d;
    logic                change_q;
    logic                change_d;
    logic [CHANNELS-1:0] s;

    // The chain runs every cycle regardless of the strobe.
    always_comb begin
        sync_d[0] = bus.in;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i]   = cnt_q[i];
            cnt_inc[i] = {1'b0, cnt_q[i]} + 1'b1;
            if (bus.sample_en) begin
                if (s[i] == out_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_inc[i] != LEN) begin
                    cnt_d[i] = cnt_inc[i][CW-1:0];
                end else begin
                    cnt_d[i]  = '0;
                    out_d[i]  = s[i];
                    rise_d[i] = s[i];
                    fall_d[i] = ~s[i];
                end
            end
        end
        change_d = |{rise_d, fall_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= RST_VEC;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
            out_q    <= RST_VEC;
            rise_q   <= '0;
            fall_q   <= '0;
            change_q <= 1'b0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            out_q    <= out_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            change_q <= change_d;
        end
    end

    assign bus.out    = out_q;
    assign bus.rise   = rise_q;
    assign bus.fall   = fall_q;
    assign bus.change = change_q;
endmodule
